traffic_intersection_ctrl: RTL and testbench

TRAFFIC_INTERSECTION_CTRL -- requirements
Module: traffic_intersection_ctrl

---
 rtl/traffic_intersection_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_intersection_ctrl.sv
// Four-way intersection controller.
// Cycles north-south and east-west greens through yellow and an all-red
// clearance. Pedestrian requests are served from the all-red clearance, and
// night mode flashes both yellows.
// All lamps are registered Moore outputs. They are decoded from the state
// being entered, so they always describe the current registered state.
module traffic_intersection_ctrl #(
  parameter int GREEN_TICKS  = 27000000,
  parameter int YELLOW_TICKS = 9000000,
  parameter int ALLRED_TICKS = 2700000,
  parameter int WALK_TICKS   = 13500000,
  parameter int FLASH_TICKS  = 13500000,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ped_req,
  input  logic night_mode,
  output logic ns_r,
  output logic ns_y,
  output logic ns_g,
  output logic ew_r,
  output logic ew_y,
  output logic ew_g,
  output logic walk,
  output logic ped_pending
);

  typedef enum logic [2:0] {
    ALL_RED,
    NS_GREEN,
    NS_YELLOW,
    EW_GREEN,
    EW_YELLOW,
    PED_WALK,
    FLASH
  } state_t;

  typedef struct packed {
    logic ns_r;
    logic ns_y;
    logic ns_g;
    logic ew_r;
    logic ew_y;
    logic ew_g;
    logic walk;
  } lamps_t;

  // Terminal counter value of each timed phase.
  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_TICKS - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_TICKS - 1);
  localparam logic [CNT_W-1:0] FLASH_LAST  = CNT_W'(FLASH_TICKS - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] phase_last;
  logic             phase_done;
  logic             next_dir, next_dir_nxt;   // 0: NS green follows ALL_RED, 1: EW
  logic             flash_lit, flash_lit_nxt;
  logic             pend_nxt;
  logic             entering_clear;
  lamps_t           lamps;

  // Lamp pattern for a given state.
  // Outside FLASH, exactly one lamp per direction is lit.
  function automatic lamps_t decode(input state_t s, input logic lit);
    lamps_t l;
    l = '0;
    case (s)
      NS_GREEN:  begin l.ns_g = 1'b1; l.ew_r = 1'b1; end
      NS_YELLOW: begin l.ns_y = 1'b1; l.ew_r = 1'b1; end
      EW_GREEN:  begin l.ns_r = 1'b1; l.ew_g = 1'b1; end
      EW_YELLOW: begin l.ns_r = 1'b1; l.ew_y = 1'b1; end
      PED_WALK:  begin l.ns_r = 1'b1; l.ew_r = 1'b1; l.walk = 1'b1; end
      FLASH:     begin l.ns_y = lit;  l.ew_y = lit; end
      default:   begin l.ns_r = 1'b1; l.ew_r = 1'b1; end
    endcase
    return l;
  endfunction

  // Select the terminal count of the phase currently being timed.
  always_comb begin
    case (state)
      NS_GREEN, EW_GREEN:   phase_last = GREEN_LAST;
      NS_YELLOW, EW_YELLOW: phase_last = YELLOW_LAST;
      PED_WALK:             phase_last = WALK_LAST;
      FLASH:                phase_last = FLASH_LAST;
      default:              phase_last = ALLRED_LAST;
    endcase
  end

  // A phase can only end on an enabled cycle, so en=0 freezes everything.
  assign phase_done = en && (cnt == phase_last);

  // Next-state, counter, direction and flash-phase logic.
  always_comb begin
    // NOTE: every signal gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    state_nxt     = state;
    cnt_nxt       = en ? cnt + CNT_W'(1) : cnt;
    next_dir_nxt  = next_dir;
    flash_lit_nxt = flash_lit;

    if (phase_done) begin
      cnt_nxt = '0;
      case (state)
        ALL_RED: begin
          if (night_mode) begin
            state_nxt     = FLASH;
            flash_lit_nxt = 1'b1;
          end else if (ped_pending) begin
            state_nxt = PED_WALK;
          end else begin
            state_nxt = next_dir ? EW_GREEN : NS_GREEN;
          end
        end
        NS_GREEN:  state_nxt = NS_YELLOW;
        NS_YELLOW: begin
          state_nxt    = ALL_RED;
          next_dir_nxt = ~next_dir;
        end
        EW_GREEN:  state_nxt = EW_YELLOW;
        EW_YELLOW: begin
          state_nxt    = ALL_RED;
          next_dir_nxt = ~next_dir;
        end
        PED_WALK:  state_nxt = next_dir ? EW_GREEN : NS_GREEN;
        FLASH: begin
          // Night mode is only examined at a half-period boundary.
          if (night_mode) begin
            flash_lit_nxt = ~flash_lit;
          end else begin
            state_nxt    = ALL_RED;
            next_dir_nxt = 1'b0;
          end
        end
        default: state_nxt = ALL_RED;
      endcase
    end
  end

  // Entering a walk or a flash serves the outstanding pedestrian request.
  // A request arriving in that same cycle survives, because set wins over clear.
  assign entering_clear = (state_nxt != state) &&
                          ((state_nxt == PED_WALK) || (state_nxt == FLASH));
  assign pend_nxt       = ped_req | (ped_pending & ~entering_clear);

  // State, counter and registered lamp outputs.
  // Reset forces the all-red clearance at once.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples the values from before the edge.
    if (!rst) begin
      state       <= ALL_RED;
      cnt         <= '0;
      next_dir    <= 1'b0;
      flash_lit   <= 1'b1;
      ped_pending <= 1'b0;
      lamps       <= decode(ALL_RED, 1'b1);
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      next_dir    <= next_dir_nxt;
      flash_lit   <= flash_lit_nxt;
      ped_pending <= pend_nxt;
      lamps       <= decode(state_nxt, flash_lit_nxt);
    end
  end

  assign ns_r = lamps.ns_r;
  assign ns_y = lamps.ns_y;
  assign ns_g = lamps.ns_g;
  assign ew_r = lamps.ew_r;
  assign ew_y = lamps.ew_y;
  assign ew_g = lamps.ew_g;
  assign walk = lamps.walk;

  // Conflicting green/yellow aspects may only coexist as the night flash.
  a_no_conflict: assert property (@(posedge clk) disable iff (!rst)
    ((ns_g || ns_y) && (ew_g || ew_y)) |-> (state == FLASH && !ns_g && !ew_g));

  // The walk lamp always has both directions held at red.
  a_walk_red: assert property (@(posedge clk) disable iff (!rst)
    walk |-> (ns_r && ew_r));

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
// Bench for traffic_intersection_ctrl.
// Directed scenarios plus random stimulus. All of them are compared every
// cycle against a phase/countdown reference model.
module tb_traffic_intersection_ctrl;

  localparam int GREEN  = 5;
  localparam int YELLOW = 2;
  localparam int ALLRED = 1;
  localparam int WALKT  = 3;
  localparam int FLASHT = 2;

  // Model phases (independent of the RTL encoding).
  localparam int P_AR    = 0;
  localparam int P_NSG   = 1;
  localparam int P_NSY   = 2;
  localparam int P_EWG   = 3;
  localparam int P_EWY   = 4;
  localparam int P_WALK  = 5;
  localparam int P_FLASH = 6;

  logic clk, rst, en, ped_req, night_mode;
  logic ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_pending;
  logic [7:0] obs;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state.
  int m_phase;
  int m_left;
  bit m_go_ew;
  bit m_pend;
  bit m_lit;

  traffic_intersection_ctrl #(
    .GREEN_TICKS (GREEN),
    .YELLOW_TICKS(YELLOW),
    .ALLRED_TICKS(ALLRED),
    .WALK_TICKS  (WALKT),
    .FLASH_TICKS (FLASHT),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .ped_req    (ped_req),
    .night_mode (night_mode),
    .ns_r       (ns_r),
    .ns_y       (ns_y),
    .ns_g       (ns_g),
    .ew_r       (ew_r),
    .ew_y       (ew_y),
    .ew_g       (ew_g),
    .walk       (walk),
    .ped_pending(ped_pending)
  );

  assign obs = {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g, walk, ped_pending};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
  endtask

  // Lamp vector {ns_r,ns_y,ns_g,ew_r,ew_y,ew_g,walk} for a phase.
  function automatic logic [6:0] lamp_of(input int ph, input bit lit);
    case (ph)
      P_NSG:   return 7'b001_100_0;
      P_NSY:   return 7'b010_100_0;
      P_EWG:   return 7'b100_001_0;
      P_EWY:   return 7'b100_010_0;
      P_WALK:  return 7'b100_100_1;
      P_FLASH: return {1'b0, lit, 1'b0, 1'b0, lit, 1'b0, 1'b0};
      default: return 7'b100_100_0;
    endcase
  endfunction

  function automatic int dur(input int ph);
    case (ph)
      P_NSG, P_EWG: return GREEN;
      P_NSY, P_EWY: return YELLOW;
      P_WALK:       return WALKT;
      P_FLASH:      return FLASHT;
      default:      return ALLRED;
    endcase
  endfunction

  task automatic model_reset();
    m_phase = P_AR;
    m_left  = ALLRED;
    m_go_ew = 1'b0;
    m_pend  = 1'b0;
    m_lit   = 1'b1;
  endtask

  // One rising edge of the model: count down the remaining cycles of the phase.
  task automatic model_step();
    bit entering;
    int nxt;
    entering = 1'b0;
    if (en) begin
      m_left--;
      if (m_left == 0) begin
        nxt = m_phase;
        case (m_phase)
          P_AR:    nxt = night_mode ? P_FLASH : (m_pend ? P_WALK : (m_go_ew ? P_EWG : P_NSG));
          P_NSG:   nxt = P_NSY;
          P_NSY:   begin nxt = P_AR; m_go_ew = !m_go_ew; end
          P_EWG:   nxt = P_EWY;
          P_EWY:   begin nxt = P_AR; m_go_ew = !m_go_ew; end
          P_WALK:  nxt = m_go_ew ? P_EWG : P_NSG;
          default: begin
            if (night_mode) m_lit = !m_lit;
            else begin nxt = P_AR; m_go_ew = 1'b0; end
          end
        endcase
        if (nxt != m_phase && (nxt == P_WALK || nxt == P_FLASH)) begin
          entering = 1'b1;
          if (nxt == P_FLASH) m_lit = 1'b1;
        end
        m_phase = nxt;
        m_left  = dur(nxt);
      end
    end
    if (entering) m_pend = 1'b0;
    if (ped_req)  m_pend = 1'b1;
  endtask

  // Advance one clock with the inputs as currently driven, then compare on the falling edge.
  task automatic cycle(input string tag);
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    check(tag, obs, {lamp_of(m_phase, m_lit), m_pend});
  endtask

  task automatic run(input int n, input string tag);
    for (int i = 0; i < n; i++) cycle(tag);
  endtask

  // Run until the model reaches a phase. The wait is bounded, and expiry counts as a failure.
  task automatic wait_phase(input int ph, input string tag);
    int k;
    k = 0;
    while (m_phase != ph && k < 40) begin
      cycle(tag);
      k++;
    end
    check({tag, "_reach"}, 8'(m_phase), 8'(ph));
  endtask

  // Reset asserted between clock edges. The outputs must react without waiting for a clock.
  task automatic do_reset(input string tag);
    #2 rst = 1'b0;
    #1 check({tag, "_async"}, obs, 8'b100_100_0_0);
    model_reset();
    @(negedge clk);
    check({tag, "_held"}, obs, 8'b100_100_0_0);
    rst = 1'b1;
  endtask

  // Hand-written power-up sequence expected after a reset release with no requests.
  task automatic check_startup(input string tag);
    int ph[7];
    int len[7];
    ph  = '{P_NSG, P_NSY, P_AR, P_EWG, P_EWY, P_AR, P_NSG};
    len = '{5, 2, 1, 5, 2, 1, 5};
    en = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
    for (int s = 0; s < 7; s++) begin
      for (int c = 0; c < len[s]; c++) begin
        cycle(tag);
        check({tag, "_seq"}, obs, {lamp_of(ph[s], 1'b1), 1'b0});
      end
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; ped_req = 1'b0; night_mode = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_state", obs, 8'b100_100_0_0);
    rst = 1'b1;

    // Free-running cycle, 16-cycle period.
    check_startup("startup");

    // Single-cycle pedestrian pulse during NS green.
    wait_phase(P_NSG, "ped_wait");
    ped_req = 1'b1;
    cycle("ped_pulse");
    ped_req = 1'b0;
    run(20, "ped_serve");

    // Request held across the walk entry edge.
    ped_req = 1'b1;
    wait_phase(P_WALK, "ped_hold");
    cycle("ped_hold_in");
    ped_req = 1'b0;
    run(30, "ped_second");

    // Enable dropped for 4 cycles mid NS green, with a request inside the window.
    wait_phase(P_NSG, "en_wait");
    run(2, "en_pre");
    en = 1'b0;
    run(2, "en_off");
    ped_req = 1'b1;
    cycle("en_off_req");
    ped_req = 1'b0;
    cycle("en_off");
    en = 1'b1;
    run(25, "en_post");

    // Night mode raised during EW green, then cleared.
    wait_phase(P_EWG, "night_wait");
    night_mode = 1'b1;
    run(20, "night_flash");
    night_mode = 1'b0;
    run(20, "night_exit");

    // Reset in the middle of EW yellow.
    wait_phase(P_EWY, "rst_wait");
    do_reset("rst_mid");
    check_startup("rst_restart");

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      en      = ($urandom_range(0, 7) != 0);
      ped_req = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 59) == 0) night_mode = !night_mode;
      if ($urandom_range(0, 399) == 0) do_reset("rand_rst");
      else cycle("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
